spi_ram_responder: RTL and testbench
====================================

# spi_ram_responder

SPI target that answers the 16-bit-address serial SRAM protocol issued by `spi_ram_controller`. It is used as a synthesizable RAM stand-in for benches and FPGA bring-up of `cpu`. All SPI inputs are oversampled in the `clk` domain and decoded by a byte-level state machine backed by an internal byte array. It supports sequential READ (0x03) and WRITE (0x02) with address auto-increment.

## Interface
Parameters:
- `ADDR_BITS`, default 8: internal memory depth is 2^ADDR_BITS bytes. Legal range 4..16.

Ports:
- `clk`  in  1  system clock; SPI signals are sampled on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high. One clock; reset is asynchronous and active-high.
- `spi_clk`  in  1  SCK from the controller, SPI mode 0.
- `spi_select`  in  1  chip select, active-low.
- `spi_mosi`  in  1  controller-to-target data, MSB first.
- `spi_miso`  out  1  target-to-controller data, MSB first.
- `active`  out  1  high while a transaction is being decoded, i.e. synchronized select is low.

## Operation
- Input conditioning:
  - `spi_clk`, `spi_select` and `spi_mosi` each pass through a 2-FF synchronizer.
  - SCK rise and fall are edge-detected from the synchronized copy.
- Frame: select falls, then an 8-bit command, then a 16-bit address (MSB first), then data bytes until select rises.
- Mode 0 timing on the wire:
  - MOSI is sampled on SCK rise.
  - MISO is updated on SCK fall.
- States:
  - IDLE: waits for select low, then goes to CMD.
  - CMD: shifts 8 bits.
    - 0x03 or 0x02 goes to ADDR.
    - Any other value goes to IGNORE.
  - ADDR: shifts 16 bits.
    - On the 16th rise, `addr` is loaded with bits [ADDR_BITS-1:0]; upper bits are discarded, so addresses alias.
    - For READ, `mem[addr]` is loaded into the TX shift register and the state goes to READ.
    - For WRITE, the state goes to WRITE.
  - READ: each SCK fall shifts TX left.
    - On the 8th rise of each byte, `addr` increments and TX reloads from `mem[addr+1]`.
  - WRITE: RX shifts on each rise.
    - On the 8th rise, `mem[addr]` takes the RX byte and `addr` increments.
  - IGNORE: MISO is held 0 until deselect.
- Select high in any state returns to IDLE.
  - The bit counter clears.
  - A partially received write byte is discarded and memory is untouched.
- The address wraps from 2^ADDR_BITS-1 to 0 in both READ and WRITE.
- Memory is not cleared by `rst`, so contents survive reset. Reset clears only the FSM, counters, shift registers and status.

## Timing
- Reset values: `spi_miso`=0, `active`=0, state IDLE, bit counter 0, `addr` 0.
- Input latency is 3 clk from a pin change to edge detection (2 synchronizer stages plus 1 edge register).
- The SCK high and low phases must each be at least 4 clk; the bench runs SCK at no more than clk/8.
- Read data alignment:
  - MISO carries data MSB from the first SCK fall after the 16th address rise, at most 4 clk after that fall.
  - That fall is after the 16th address rise and before the first data rise.
- MISO is 0 in IDLE, CMD, ADDR and IGNORE.
- A write commits 1 clk after the 8th data rise is detected.
- Select rise is seen in 3 clk. A new select fall is accepted in the clk immediately after IDLE is re-entered.
- If select rise and SCK rise are detected in the same clk, deselect wins and the bit is dropped.
- `active` follows synchronized select with 3 clk latency.

## Configuration
- `SPI_RAM_RESPONDER_STATUS_EN` defined:
  - Adds an 8-bit status register, reset value 0x40.
  - Command 0x05 (RDSR) returns status repeatedly, MSB first, until deselect; the first bit appears on the fall after the command byte.
  - Command 0x01 (WRSR) writes the next full byte to status; further bytes are ignored.
  - Status has no effect on READ/WRITE, which are always sequential.
- Macro undefined: no status register; 0x05 and 0x01 go to IGNORE.

## Structure
- Package `spi_ram_pkg`:
  - Command constants `CMD_READ`=0x03, `CMD_WRITE`=0x02, `CMD_RDSR`=0x05, `CMD_WRSR`=0x01.
  - State enum (IDLE, CMD, ADDR, READ, WRITE, STATUS_RD, STATUS_WR, IGNORE).
  - `SPI_ADDR_PHASE_BITS`=16.
- Sub-module `spi_sync_edge`: 2-FF synchronizer plus rise/fall detect, instantiated for SCK and select. MOSI uses the synchronizer only.
- The memory array, shift registers and FSM live in the top module.

## Test plan
- Write/read back: WRITE at 0x0010 with 0xA5, 0x3C, deselect; then READ at 0x0010 for 2 bytes → MISO returns 0xA5, 0x3C.
- Wrap: with ADDR_BITS=8, WRITE at 0x00FF with 0x11, 0x22 → READ at 0x0000 returns 0x22 and READ at 0x00FF returns 0x11. Alias check: READ at 0x01FF returns 0x11.
- Abort: WRITE at 0x0020 with 0x77, then deselect after 5 data bits → READ at 0x0020 returns the prior value; `active` falls 3 clk after select rises.
- Unknown command 0x9F followed by 32 clocks → MISO stays 0 and memory is unchanged; the next READ is decoded normally.
- Reset mid-READ: assert `rst` during data bit 3 → `spi_miso`=0 and `active`=0 immediately; after release, a fresh READ returns the memory contents intact.
- With `SPI_RAM_RESPONDER_STATUS_EN`: RDSR → 0x40, 0x40; WRSR 0x00 then RDSR → 0x00. Without the macro, RDSR → MISO 0.

Source files
------------

// File: rtl/spi_ram_responder_pkg.sv
// spi_ram_pkg: command codes, FSM states and framing constants for spi_ram_responder
package spi_ram_pkg;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_RDSR  = 8'h05;
  localparam logic [7:0] CMD_WRSR  = 8'h01;
  localparam int SPI_ADDR_PHASE_BITS = 16;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, WRITE, STATUS_RD, STATUS_WR, IGNORE} state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-FF synchronizer with rise/fall detect against a third delayed stage
module spi_sync_edge #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [2:0] s;
  // two synchronizer stages plus one edge-reference stage
  always_ff @(posedge clk or posedge rst)
    if (rst) s <= {3{INIT}};
    else s <= {s[1:0], d};
  assign q = s[1];
  assign rise = s[1] & ~s[2];
  assign fall = ~s[1] & s[2];
endmodule

// File: rtl/spi_ram_responder.sv
// spi_ram_responder: SPI mode-0 serial SRAM target; SPI_RAM_RESPONDER_STATUS_EN adds RDSR/WRSR status register
module spi_ram_responder
  import spi_ram_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_clk,
  input  logic spi_select,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic active
);
  logic sck_rise, sck_fall, sck_q, sel_q, sel_rise, sel_fall, is_read;
  logic [1:0] mosi_s;
  logic [3:0] cnt;
  logic [15:0] sr, shin;
  logic [7:0] tx;
  logic [ADDR_BITS-1:0] addr, addr_nx, la;
  logic [7:0] mem [0:(1<<ADDR_BITS)-1];
  logic last8, last16, unused;
  state_t state, state_nx, cmd_nx;
`ifdef SPI_RAM_RESPONDER_STATUS_EN
  logic [7:0] status;
`endif
  spi_sync_edge #(.INIT(1'b0)) u_sck (.clk(clk), .rst(rst), .d(spi_clk), .q(sck_q), .rise(sck_rise), .fall(sck_fall));
  spi_sync_edge #(.INIT(1'b1)) u_sel (.clk(clk), .rst(rst), .d(spi_select), .q(sel_q), .rise(sel_rise), .fall(sel_fall));
  assign unused = sck_q ^ sel_rise ^ sel_fall;
  // MOSI needs only the synchronizer; it lines up with the SCK edge detect
  always_ff @(posedge clk or posedge rst)
    if (rst) mosi_s <= 2'b00;
    else mosi_s <= {mosi_s[0], spi_mosi};
  assign shin = {sr[14:0], mosi_s[1]};
  assign la = shin[ADDR_BITS-1:0];
  assign addr_nx = addr + 1'b1;
  assign last8 = sck_rise && cnt[2:0] == 3'd7;
  assign last16 = sck_rise && cnt == 4'(SPI_ADDR_PHASE_BITS - 1);
`ifdef SPI_RAM_RESPONDER_STATUS_EN
  assign cmd_nx = (shin[7:0] == CMD_READ || shin[7:0] == CMD_WRITE) ? ADDR :
                  shin[7:0] == CMD_RDSR ? STATUS_RD :
                  shin[7:0] == CMD_WRSR ? STATUS_WR : IGNORE;
`else
  assign cmd_nx = (shin[7:0] == CMD_READ || shin[7:0] == CMD_WRITE) ? ADDR : IGNORE;
`endif
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next state: deselect overrides everything, including a coincident SCK rise
  always_comb begin
    state_nx = state;
    if (sel_q) state_nx = IDLE;
    else
      case (state)
        IDLE:      state_nx = CMD;
        CMD:       state_nx = last8 ? cmd_nx : CMD;
        ADDR:      state_nx = last16 ? (is_read ? READ : WRITE) : ADDR;
        STATUS_WR: state_nx = last8 ? IGNORE : STATUS_WR;
        default:   state_nx = state;
      endcase
  end
  // shift registers, bit counter, address pointer and MISO driver
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      sr <= '0;
      tx <= '0;
      addr <= '0;
      is_read <= 1'b0;
      spi_miso <= 1'b0;
      active <= 1'b0;
`ifdef SPI_RAM_RESPONDER_STATUS_EN
      status <= 8'h40;
`endif
    end else begin
      active <= ~sel_q;
      if (sel_q) begin
        cnt <= '0;
        spi_miso <= 1'b0;
      end else begin
        if (sck_rise) begin
          sr <= shin;
          cnt <= cnt + 4'd1;
        end
        case (state)
          IDLE: cnt <= '0;
          CMD:
            if (last8) begin
              cnt <= '0;
              is_read <= shin[7:0] == CMD_READ;
`ifdef SPI_RAM_RESPONDER_STATUS_EN
              tx <= status;
`endif
            end
          ADDR:
            if (last16) begin
              cnt <= '0;
              addr <= la;
              tx <= mem[la];
            end
          READ:
            if (sck_fall) begin
              spi_miso <= tx[7];
              tx <= {tx[6:0], 1'b0};
            end else if (last8) begin
              cnt <= '0;
              addr <= addr_nx;
              tx <= mem[addr_nx];
            end
          WRITE:
            if (last8) begin
              cnt <= '0;
              addr <= addr_nx;
            end
`ifdef SPI_RAM_RESPONDER_STATUS_EN
          STATUS_RD:
            if (sck_fall) begin
              spi_miso <= tx[7];
              tx <= {tx[6:0], tx[7]};
            end
          STATUS_WR:
            if (last8) status <= shin[7:0];
`endif
          default: spi_miso <= 1'b0;
        endcase
      end
    end
  // byte array is deliberately outside reset so contents survive it
  always_ff @(posedge clk)
    if (state == WRITE && !sel_q && last8) mem[addr] <= shin[7:0];
endmodule

// File: tb/tb_spi_ram_responder.sv
// tb_spi_ram_responder: scoreboard bench driving SPI frames and checking MISO bytes
module tb_spi_ram_responder;
  localparam int H = 6;
  logic clk = 0, rst = 1, spi_clk = 0, spi_select = 1, spi_mosi = 0;
  logic spi_miso, active;
  int errors = 0, checks = 0;
  logic [7:0] exp_q[$];
  logic cap = 0;
  logic [7:0] mon_sh = 0;
  int mon_n = 0;

  spi_ram_responder #(.ADDR_BITS(8)) dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_select(spi_select),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .active(active)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: controller-side capture of MISO on SCK rise, compared against the scoreboard
  always @(posedge spi_clk)
    if (cap) begin
      mon_sh = {mon_sh[6:0], spi_miso};
      mon_n++;
      if (mon_n == 8) begin
        mon_n = 0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL miso_byte: got %h with no expected byte queued", mon_sh);
        end else check("miso_byte", mon_sh, exp_q.pop_front());
      end
    end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_out(input logic b);
    spi_mosi = b;
    clks(H);
    spi_clk = 1;
    clks(H);
    spi_clk = 0;
  endtask

  task automatic byte_out(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
  endtask

  task automatic sel_on();
    clks(2);
    spi_select = 0;
    clks(4);
  endtask

  task automatic sel_off();
    clks(2);
    spi_select = 1;
    clks(8);
  endtask

  task automatic hdr(input logic [7:0] c, input logic [15:0] a);
    sel_on();
    byte_out(c);
    byte_out(a[15:8]);
    byte_out(a[7:0]);
  endtask

  task automatic wr(input logic [15:0] a, input int n, input logic [7:0] d0, input logic [7:0] d1);
    hdr(8'h02, a);
    byte_out(d0);
    if (n > 1) byte_out(d1);
    sel_off();
  endtask

  task automatic rd(input logic [15:0] a, input int n, input logic [7:0] e0, input logic [7:0] e1);
    hdr(8'h03, a);
    exp_q.push_back(e0);
    if (n > 1) exp_q.push_back(e1);
    cap = 1;
    repeat (n) byte_out(8'h00);
    cap = 0;
    sel_off();
  endtask

  task automatic rdsr(input logic [7:0] e);
    sel_on();
    byte_out(8'h05);
    exp_q.push_back(e);
    exp_q.push_back(e);
    cap = 1;
    repeat (2) byte_out(8'h00);
    cap = 0;
    sel_off();
  endtask

  initial begin
    clks(3);
    rst = 0;
    clks(2);
    check("reset_miso", {7'b0, spi_miso}, 8'h00);
    check("reset_active", {7'b0, active}, 8'h00);
    wr(16'h0010, 2, 8'hA5, 8'h3C);
    rd(16'h0010, 2, 8'hA5, 8'h3C);
    wr(16'h00FF, 2, 8'h11, 8'h22);
    rd(16'h0000, 1, 8'h22, 8'h00);
    rd(16'h00FF, 2, 8'h11, 8'h22);
    rd(16'h01FF, 1, 8'h11, 8'h00);
    wr(16'h0020, 1, 8'h5A, 8'h00);
    hdr(8'h02, 16'h0020);
    bit_out(0); bit_out(1); bit_out(1); bit_out(1); bit_out(0);
    clks(2);
    spi_select = 1;
    clks(2);
    check("active_hold_2clk", {7'b0, active}, 8'h01);
    clks(1);
    check("active_fall_3clk", {7'b0, active}, 8'h00);
    clks(8);
    rd(16'h0020, 1, 8'h5A, 8'h00);
    sel_on();
    byte_out(8'h9F);
    repeat (4) exp_q.push_back(8'h00);
    cap = 1;
    repeat (4) byte_out(8'hFF);
    cap = 0;
    sel_off();
    rd(16'h0010, 2, 8'hA5, 8'h3C);
    hdr(8'h03, 16'h0010);
    bit_out(0);
    bit_out(0);
    spi_mosi = 0;
    clks(H);
    spi_clk = 1;
    clks(2);
    check("pre_reset_miso", {7'b0, spi_miso}, 8'h01);
    rst = 1;
    #1;
    check("rst_miso", {7'b0, spi_miso}, 8'h00);
    check("rst_active", {7'b0, active}, 8'h00);
    spi_clk = 0;
    spi_select = 1;
    clks(3);
    rst = 0;
    clks(8);
    rd(16'h0010, 2, 8'hA5, 8'h3C);
    rd(16'h0020, 1, 8'h5A, 8'h00);
`ifdef SPI_RAM_RESPONDER_STATUS_EN
    rdsr(8'h40);
    sel_on();
    byte_out(8'h01);
    byte_out(8'h00);
    byte_out(8'hFF);
    sel_off();
    rdsr(8'h00);
`else
    rdsr(8'h00);
`endif
    clks(10);
    check("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
